// File: rtl/spi_frame_rx_pkg.sv
// ============================================================================
// spi_frame_rx_pkg : shared state encoding, target codes and widths
// Optional build macro: FRAME_PARITY_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package spi_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic TGT_ICACHE = 1'b0;
  localparam logic TGT_DCACHE = 1'b1;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

`ifdef FRAME_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Bit-counter width for a frame of frame_w bits (never narrower than 1).
  function automatic int cnt_w(input int frame_w);
    return ($clog2(frame_w) < 1) ? 1 : $clog2(frame_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_rx_frame_shifter.sv
// ============================================================================
// spi_frame_rx_frame_shifter : MSB-first shift register plus bit counter
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module spi_frame_rx_frame_shifter
  import spi_frame_rx_pkg::*;
#(
  parameter int FRAME_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               serial_in,
  output logic [FRAME_W-1:0] frame,
  output logic               done
);

  localparam int CNT_W = cnt_w(FRAME_W);

  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    done  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (shift_en) begin
      sr_d = {sr_q[FRAME_W-2:0], serial_in};
      if (cnt_q == CNT_W'(FRAME_W - 1)) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // The next-state view lets the parent capture the frame including the bit
  // being sampled on the completing edge.
  assign frame = sr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_frame_rx.sv
// ============================================================================
// spi_frame_rx : serial frame loader issuing single-cycle cache write strobes
// Optional build macro: FRAME_PARITY_EN (trailing even-parity bit)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module spi_frame_rx
  import spi_frame_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csi_n_in,
  input  logic              csd_n_in,
  input  logic              mosi_in,
  input  logic              proc_en_in,
  input  logic              clr_err_in,
  output logic              wr_en_out,
  output logic              wr_tgt_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic              busy_out,
  output logic              frame_err_out
);

  localparam int FRAME_W = DATA_W + ADDR_W + PARITY_W;

  state_e             state_q, state_d;
  logic               tgt_q, tgt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_q, err_d;
  logic               err_set;

  logic               shift_en;
  logic               clear;
  logic               done;
  logic [FRAME_W-1:0] frame;
  logic               frame_ok;
  logic               cs_own_n;
  logic               cs_oth_n;

  spi_frame_rx_frame_shifter #(
    .FRAME_W (FRAME_W)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (clear),
    .serial_in (mosi_in),
    .frame     (frame),
    .done      (done)
  );

`ifdef FRAME_PARITY_EN
  assign frame_ok = ~(^frame);
`else
  assign frame_ok = 1'b1;
`endif

  assign cs_own_n = (tgt_q == TGT_DCACHE) ? csd_n_in : csi_n_in;
  assign cs_oth_n = (tgt_q == TGT_DCACHE) ? csi_n_in : csd_n_in;

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_set  = 1'b0;
    shift_en = 1'b0;
    clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (!proc_en_in) begin
          if (!csi_n_in && !csd_n_in) begin
            err_set = 1'b1;
          end else if (!csi_n_in || !csd_n_in) begin
            clear    = 1'b0;
            shift_en = 1'b1;
            tgt_d    = csd_n_in ? TGT_ICACHE : TGT_DCACHE;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (proc_en_in || cs_own_n || !cs_oth_n) begin
          err_set = 1'b1;
          clear   = 1'b1;
          state_d = IDLE;
        end else begin
          shift_en = 1'b1;
          if (done) begin
            if (frame_ok) begin
              wr_en_d = 1'b1;
              data_d  = frame[FRAME_W-1 -: DATA_W];
              addr_d  = frame[FRAME_W-1-DATA_W -: ADDR_W];
              state_d = COMMIT;
            end else begin
              err_set = 1'b1;
              state_d = HOLD;
            end
          end
        end
      end
      COMMIT: begin
        clear   = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // Trailing bits are dropped until the bus is released.
        clear = 1'b1;
        if (csi_n_in && csd_n_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    err_d = err_set | (err_q & ~clr_err_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= TGT_ICACHE;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign wr_en_out     = wr_en_q;
  assign wr_tgt_out    = tgt_q;
  assign wr_addr_out   = addr_q;
  assign wr_data_out   = data_q;
  assign busy_out      = (state_q != IDLE);
  assign frame_err_out = err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_rx.sv
// ============================================================================
// tb_spi_frame_rx : vector table, corner sequences and random frames vs model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_rx;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef FRAME_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int FW = DW + AW + PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csi_n = 1'b1;
  logic          csd_n = 1'b1;
  logic          mosi = 1'b0;
  logic          proc_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          wr_en, wr_tgt, busy, ferr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cyc = -1;
  logic [AW+DW:0] wq[$];

  spi_frame_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csi_n_in      (csi_n),
    .csd_n_in      (csd_n),
    .mosi_in       (mosi),
    .proc_en_in    (proc_en),
    .clr_err_in    (clr_err),
    .wr_en_out     (wr_en),
    .wr_tgt_out    (wr_tgt),
    .wr_addr_out   (wr_addr),
    .wr_data_out   (wr_data),
    .busy_out      (busy),
    .frame_err_out (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_tgt, wr_addr, wr_data});
      wr_cyc <= cyc;
    end
  end

  typedef struct {
    int            cs_sel;   // 0 icache, 1 dcache, 2 both
    int            nbits;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int            proc_at;
    int            other_at;
    int            exp_w;
    bit            exp_err;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] mkframe(input logic [DW-1:0] d, input logic [AW-1:0] a);
`ifdef FRAME_PARITY_EN
    return {d, a, ^{d, a}};
`else
    return {d, a};
`endif
  endfunction

  task automatic send(input int cs_sel, input int nbits, input logic [FW-1:0] frame,
                      input int proc_at, input int other_at);
    logic oth;
    for (int i = 0; i < nbits; i++) begin
      mosi    = (i < FW) ? frame[FW-1-i] : 1'($urandom);
      proc_en = (proc_at >= 0) && (i >= proc_at);
      oth     = (other_at >= 0) && (i >= other_at);
      if (cs_sel == 0) begin
        csi_n = 1'b0;
        csd_n = !oth;
      end else if (cs_sel == 1) begin
        csd_n = 1'b0;
        csi_n = !oth;
      end else begin
        csi_n = 1'b0;
        csd_n = 1'b0;
      end
      tick();
    end
    csi_n   = 1'b1;
    csd_n   = 1'b1;
    proc_en = 1'b0;
    mosi    = 1'b0;
    repeat (3) tick();
  endtask

  task automatic verify(input string name, input int exp_w, input bit exp_err,
                        input logic [FW-1:0] frame, input logic tgt);
    chk({name, " writes"}, wq.size(), exp_w);
    if (exp_w == 1 && wq.size() == 1)
      chk({name, " payload"}, wq[0], {tgt, frame[FW-1-DW -: AW], frame[FW-1 -: DW]});
    chk({name, " err"}, ferr, exp_err);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk({name, " err_clr"}, ferr, 0);
    wq.delete();
  endtask

  // Outcome of one framed burst, reasoned from the framing rules only.
  function automatic void ref_model(input int cs_sel, input int nbits, input int proc_at,
                                    input int other_at, input logic [FW-1:0] frame,
                                    output int exp_w, output bit exp_err);
    int first_bad;
    exp_w   = 0;
    exp_err = 1'b0;
    if (nbits == 0 || proc_at == 0) return;
    if (cs_sel == 2 || other_at == 0) begin
      exp_err = 1'b1;
      return;
    end
    first_bad = nbits;
    if (proc_at >= 0 && proc_at < first_bad) first_bad = proc_at;
    if (other_at >= 0 && other_at < first_bad) first_bad = other_at;
    if (first_bad < FW) begin
      exp_err = 1'b1;
      return;
    end
    if (PW == 1 && (^frame) != 1'b0) begin
      exp_err = 1'b1;
      return;
    end
    exp_w = 1;
  endfunction

  initial begin
    logic [FW-1:0] fr, fb;
    int            s, ew, nb, pa, oa, cs, busy_lo;
    bit            ee;

    vt[0] = '{0, FW,     8'hA5, 4'h3, -1, -1, 1, 1'b0};
    vt[1] = '{1, FW,     8'h7F, 4'hE, -1, -1, 1, 1'b0};
    vt[2] = '{0, 7,      8'h3C, 4'h1, -1, -1, 0, 1'b1};
    vt[3] = '{2, FW,     8'h11, 4'h2, -1, -1, 0, 1'b1};
    vt[4] = '{0, FW,     8'hC3, 4'h5,  5, -1, 0, 1'b1};
    vt[5] = '{0, FW,     8'hC3, 4'h5,  0, -1, 0, 1'b0};
    vt[6] = '{1, FW,     8'h99, 4'h4, -1,  4, 0, 1'b1};
    vt[7] = '{1, FW,     8'h00, 4'h0, -1, -1, 1, 1'b0};
    vt[8] = '{0, FW + 3, 8'hFF, 4'hF, -1, -1, 1, 1'b0};
    vt[9] = '{0, FW - 1, 8'h5A, 4'h6, -1, -1, 0, 1'b1};

    // Reset state
    repeat (2) tick();
    chk("rst wr_en", wr_en, 0);
    chk("rst busy", busy, 0);
    chk("rst err", ferr, 0);
    chk("rst tgt", wr_tgt, 0);
    chk("rst addr", wr_addr, 0);
    chk("rst data", wr_data, 0);
    rst_n = 1'b1;
    tick();

    foreach (vt[k]) begin
      fr = mkframe(vt[k].d, vt[k].a);
      s  = cyc;
      send(vt[k].cs_sel, vt[k].nbits, fr, vt[k].proc_at, vt[k].other_at);
      if (k == 0) chk("latency", wr_cyc, s + FW);
      verify($sformatf("vec%0d", k), vt[k].exp_w, vt[k].exp_err, fr, vt[k].cs_sel == 1);
    end

    // Back-to-back: dcache frame held through the strobe, one idle cycle, then icache frame
    fr = mkframe(8'h7F, 4'hE);
    fb = mkframe(8'h5A, 4'h6);
    for (int i = 0; i < FW + 1; i++) begin
      csd_n = 1'b0;
      mosi  = (i < FW) ? fr[FW-1-i] : 1'b1;
      tick();
    end
    csd_n = 1'b1;
    tick();
    send(0, FW, fb, -1, -1);
    chk("b2b writes", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("b2b first", wq[0], {1'b1, 4'hE, 8'h7F});
      chk("b2b second", wq[1], {1'b0, 4'h6, 8'h5A});
    end
    chk("b2b err", ferr, 0);
    wq.delete();

    // Overlong frame: busy must stay high until CS is released
    fr = mkframe(8'h3C, 4'h9);
    busy_lo = 0;
    for (int i = 0; i < 20; i++) begin
      csi_n = 1'b0;
      mosi  = (i < FW) ? fr[FW-1-i] : 1'($urandom);
      tick();
      if (!busy) busy_lo++;
    end
    chk("overlong busy", busy_lo, 0);
    csi_n = 1'b1;
    tick();
    chk("overlong idle", busy, 0);
    verify("overlong", 1, 1'b0, fr, 1'b0);

    // Set and clear in the same cycle: set wins
    csi_n   = 1'b0;
    csd_n   = 1'b0;
    clr_err = 1'b1;
    tick();
    csi_n   = 1'b1;
    csd_n   = 1'b1;
    clr_err = 1'b0;
    chk("set_wins err", ferr, 1);
    tick();
    verify("set_wins", 0, 1'b1, fr, 1'b0);

    // Reset in the middle of a frame
    fr = mkframe(8'hE7, 4'hB);
    for (int i = 0; i < 6; i++) begin
      csi_n = 1'b0;
      mosi  = fr[FW-1-i];
      tick();
    end
    rst_n = 1'b0;
    #2;
    chk("midrst busy", busy, 0);
    csi_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (FW + 2) tick();
    verify("midrst", 0, 1'b0, fr, 1'b0);

`ifdef FRAME_PARITY_EN
    fr = mkframe(8'hA5, 4'h3) ^ FW'(1);
    send(0, FW, fr, -1, -1);
    verify("badpar", 0, 1'b1, fr, 1'b0);
`endif

    // Randomized frames against the reference model
    for (int r = 0; r < 60; r++) begin
      cs = int'($urandom % 2);
      nb = int'($urandom_range(1, FW + 6));
      pa = ($urandom % 4 == 0) ? int'($urandom_range(0, FW + 2)) : -1;
      oa = ($urandom % 4 == 0) ? int'($urandom_range(0, FW + 2)) : -1;
      fr = FW'($urandom);
      if (PW == 1 && ($urandom % 2 == 0)) fr[0] = ^fr[FW-1:1];
      ref_model(cs, nb, pa, oa, fr, ew, ee);
      send(cs, nb, fr, pa, oa);
      verify($sformatf("rnd%0d", r), ew, ee, fr, cs == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
Serial program/data loader that sits directly upstream of the processor's instruction and data caches. It assembles fixed-length frames from the chip-select/MOSI pins, checks their length, and issues a single-cycle write strobe with target, address and data. The cache write ports consume this strobe. It replaces the bare shift buffer and the implicit RECV/WRITE handling, and adds explicit framing and error reporting. The serial bit clock is clk, so MOSI is sampled on clk rising edges.

Parameters:
DATA_W, 8, data field width in bits
ADDR_W, 4, address field width in bits
FRAME_W, DATA_W+ADDR_W (+1 with parity), total bits per frame; derived, not overridable

Ports:
clk  input  1  system clock, also the serial bit clock
rst_n  input  1  asynchronous active-low reset
csi_n_in  input  1  instruction-cache chip select, active low
csd_n_in  input  1  data-cache chip select, active low
mosi_in  input  1  serial data, MSB first
proc_en_in  input  1  processor running; frames are refused while high
clr_err_in  input  1  single-cycle pulse that clears frame_err_out
wr_en_out  output  1  single-cycle write strobe
wr_tgt_out  output  1  0 = icache, 1 = dcache
wr_addr_out  output  ADDR_W  write address
wr_data_out  output  DATA_W  write data
busy_out  output  1  high when not in IDLE
frame_err_out  output  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-low on rst_n; one clock, clk. On reset all outputs are 0, state is IDLE and the bit counter is 0.
- Frame layout, first bit received first: data[DATA_W-1] … data[0], addr[ADDR_W-1] … addr[0], then parity if enabled.
- State machine (2-bit encoding):
  - IDLE: exactly one CS low and proc_en_in low → go to SHIFT. Latch wr_tgt (csd_n low → 1). Sample mosi in this same cycle as bit 0.
  - IDLE with both CS low → stay in IDLE and set the error flag.
  - IDLE with proc_en_in high → CS is ignored and no error is raised.
  - SHIFT: sample one bit per cycle while the latched CS stays low.
    - When bit FRAME_W-1 is sampled → go to COMMIT.
    - Latched CS high before FRAME_W bits → go to IDLE, no write, set error.
    - proc_en_in high → go to IDLE, no write, set error.
    - The other CS going low mid-frame → set error and abort the frame.
  - COMMIT: wr_en_out=1 for exactly one cycle, with addr and data valid in that same cycle. Latency is the cycle after the last bit is sampled. Next state is HOLD.
  - HOLD: wait until both CS are high, then go to IDLE. Extra bits in HOLD are ignored and raise no error. Back-to-back frames therefore need at least one cycle of CS high.
- wr_addr_out and wr_data_out are registered. They hold their last value outside COMMIT.
- Error flag: if set and clear happen in the same cycle, set wins. The flag persists until clr_err_in or reset.
- Reset asserted mid-frame: the partial frame is discarded and no strobe is issued.

Optional Feature:
FRAME_PARITY_EN
- Defined: FRAME_W gains 1 trailing even-parity bit covering data and addr.
  - On mismatch, COMMIT is replaced by HOLD: no write, error set.
- Undefined: there is no parity bit, FRAME_W = DATA_W+ADDR_W, and no parity logic is generated.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE/SHIFT/COMMIT/HOLD;
  - the target constants TGT_ICACHE=0 and TGT_DCACHE=1;
  - the DATA_W/ADDR_W defaults;
  - a CLOG2-derived counter width for FRAME_W.
- One natural sub-module: frame_shifter. It is a FRAME_W-bit MSB-first shift register plus bit counter, with ports shift_en, clear, done and the parallel output.

Test Plan:
- Nominal icache write: csi_n low for 12 cycles with bits 1010_0101_0011 → wr_en_out pulses 1 cycle in cycle 12 (first bit = cycle 0), wr_tgt_out=0, wr_addr_out=0x3, wr_data_out=0xA5.
- Nominal dcache write: csd_n low, frame 0x7F/0xE → wr_tgt_out=1, addr 0xE, data 0x7F. Back-to-back frame after 1 CS-high cycle is also accepted.
- Short frame: csi_n rises after 7 bits → no wr_en_out, frame_err_out=1. clr_err_in pulse → frame_err_out=0 next cycle.
- Both CS low in IDLE, or proc_en_in raised at bit 5 → no write, frame_err_out=1. proc_en_in high in IDLE with csi_n low → no activity and no error.
- Overlong frame: 20 bits with CS low → exactly one write using the first 12 bits, and busy_out stays high until CS rises.
- FRAME_PARITY_EN: frame 0xA5/0x3 with correct parity bit 0 → write. Same frame with parity 1 → no write, frame_err_out=1.
